// File: rtl/mem_arbiter.sv
// Three-requester arbiter (DMA, CPU data, CPU fetch) in front of a 4-phase memory interpreter.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rq_ren,
    input  logic [2:0]  rq_wen,
    input  logic [95:0] rq_addr,
    input  logic [95:0] rq_data_i,
    output logic [2:0]  rq_ack,
    output logic [31:0] rq_data_o,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_i,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic        mem_ack,
    input  logic [31:0] mem_data_o,
    output logic [2:0]  grant,
    output logic [2:0]  arb_state,
    output logic        arb_timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ISSUE   = 3'b010,
        RELEASE = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  rq_ack_q, rq_ack_d;
    logic [31:0] rq_data_q, rq_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [2:0]  req_s;
    logic [2:0]  win_s;
    logic [1:0]  win_idx_s;
    logic        owner_busy_s;

    assign req_s        = rq_ren | rq_wen;
    assign win_s        = 3'b001 << win_idx_s;
    assign owner_busy_s = |(req_s & grant_q);

`ifdef MEM_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin winner: first requester found searching upward from the one after the last grant
    always_comb begin
        logic [1:0] cand;
        logic       found;
        cand      = ptr_q;
        found     = 1'b0;
        win_idx_s = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = next_idx(cand);
            if (!found && req_s[cand]) begin
                found     = 1'b1;
                win_idx_s = cand;
            end else begin
                found     = found;
            end
        end
    end

    // Pointer follows the grant; starts at 2 so requester 0 leads after reset
    always_comb begin
        if ((state_q == IDLE) && (req_s != 3'b000)) begin
            ptr_d = win_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd2;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority winner: lowest requesting index
    always_comb begin
        if (req_s[0]) begin
            win_idx_s = 2'd0;
        end else if (req_s[1]) begin
            win_idx_s = 2'd1;
        end else begin
            win_idx_s = 2'd2;
        end
    end
`endif

    // Next-state and registered-output computation for the IDLE/ISSUE/RELEASE handshake
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rq_ack_d    = rq_ack_q;
        rq_data_d   = rq_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_s != 3'b000) begin
                    state_d     = ISSUE;
                    grant_d     = win_s;
                    mem_addr_d  = rq_addr[{win_idx_s, 5'd0} +: 32];
                    mem_wdata_d = rq_data_i[{win_idx_s, 5'd0} +: 32];
                    // A requester raising both strobes is treated as a read
                    mem_ren_d   = rq_ren[win_idx_s];
                    mem_wen_d   = ~rq_ren[win_idx_s];
                    cnt_d       = 8'd0;
                end else begin
                    state_d     = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d   = RELEASE;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    rq_ack_d  = grant_q;
                    rq_data_d = mem_ren_q ? mem_data_o : 32'd0;
                end else if (cnt_q >= (TIMEOUT_CYCLES - 8'd1)) begin
                    state_d   = RELEASE;
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    rq_ack_d  = grant_q;
                    rq_data_d = 32'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                // Both sides of the 4-phase handshake must be low before the slot is freed
                if (!mem_ack && !owner_busy_s) begin
                    state_d   = IDLE;
                    rq_ack_d  = 3'b000;
                    grant_d   = 3'b000;
                    rq_data_d = 32'd0;
                end else begin
                    state_d   = RELEASE;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 3'b000;
                rq_ack_d  = 3'b000;
                rq_data_d = 32'd0;
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            rq_ack_q    <= 3'b000;
            rq_data_q   <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rq_ack_q    <= rq_ack_d;
            rq_data_q   <= rq_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rq_ack      = rq_ack_q;
    assign rq_data_o   = rq_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_i  = mem_wdata_q;
    assign mem_ren     = mem_ren_q;
    assign mem_wen     = mem_wen_q;
    assign grant       = grant_q;
    assign arb_state   = state_q;
    assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected transactions, a memory
// responder with configurable ack delay/hold, and requesters that drop on acknowledge.
module tb_mem_arbiter;

    localparam logic [2:0]  S_IDLE    = 3'b001;
    localparam logic [2:0]  S_ISSUE   = 3'b010;
    localparam logic [2:0]  S_RELEASE = 3'b100;
    localparam logic [31:0] KEY       = 32'h5EAD_BEFF;
    localparam logic [31:0] IDLE_DATA = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rq_ren, rq_wen, rq_ack, grant, arb_state;
    logic [95:0] rq_addr, rq_data_i;
    logic [31:0] rq_data_o, mem_addr, mem_data_i, mem_data_o;
    logic        mem_ren, mem_wen, mem_ack, arb_timeout;

    typedef struct {
        logic [2:0]  gnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic [31:0] rdata;
        logic        to;
        int          issue;
        int          dur;
        logic        b2b;
    } item_t;

    item_t sb[$];
    item_t cur;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_delay, ack_hold, req_hold;
    logic never_ack;
    int req_cycles = 0;
    int hold_cnt   = 0;
    int issue_len  = 0;
    int ack_len    = 0;
    int fall_cyc   = 0;
    int drop_cnt [3];
    logic       prev_mem = 1'b0;
    logic [2:0] prev_ack = 3'b000;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .rq_ren      (rq_ren),
        .rq_wen      (rq_wen),
        .rq_addr     (rq_addr),
        .rq_data_i   (rq_data_i),
        .rq_ack      (rq_ack),
        .rq_data_o   (rq_data_o),
        .mem_addr    (mem_addr),
        .mem_data_i  (mem_data_i),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_ack     (mem_ack),
        .mem_data_o  (mem_data_o),
        .grant       (grant),
        .arb_state   (arb_state),
        .arb_timeout (arb_timeout)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic [31:0] rdat, input logic to,
                        input int iss, input int dur, input logic b2b);
        item_t it;
        it.gnt = g; it.addr = a; it.wdata = d; it.rd = rd; it.rdata = rdat;
        it.to = to; it.issue = iss; it.dur = dur; it.b2b = b2b;
        sb.push_back(it);
    endtask

    task automatic drive(input int i, input logic rd, input logic [31:0] a, input logic [31:0] d);
        rq_addr[32*i +: 32]   = a;
        rq_data_i[32*i +: 32] = d;
        rq_ren[i]             = rd;
        rq_wen[i]             = !rd;
    endtask

    task automatic step();
        logic mem_act;
        @(posedge clk);
        #1;
        cyc++;
        mem_act = mem_ren | mem_wen;
        if (mem_act) begin
            req_cycles++;
            hold_cnt = 0;
            if (!never_ack && req_cycles >= ack_delay) begin
                mem_ack    = 1'b1;
                mem_data_o = mem_addr ^ KEY;
            end
        end else begin
            req_cycles = 0;
            if (mem_ack) begin
                if (hold_cnt < ack_hold) begin
                    hold_cnt++;
                end else begin
                    mem_ack    = 1'b0;
                    mem_data_o = IDLE_DATA;
                    hold_cnt   = 0;
                end
            end
        end

        check("ren_wen_excl", 32'(mem_ren & mem_wen), 32'd0);
        if (mem_act && !prev_mem) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", 32'(grant), 32'd0);
            end else begin
                check("issue_grant", 32'(grant), 32'(sb[0].gnt));
                check("issue_addr", mem_addr, sb[0].addr);
                check("issue_wdata", mem_data_i, sb[0].wdata);
                check("issue_ren", 32'(mem_ren), 32'(sb[0].rd));
                check("issue_wen", 32'(mem_wen), 32'(!sb[0].rd));
                check("issue_state", 32'(arb_state), 32'(S_ISSUE));
                if (sb[0].b2b) check("idle_gap", 32'(cyc - fall_cyc), 32'd1);
            end
            issue_len = 1;
        end else if (mem_act) begin
            issue_len++;
        end else if (prev_mem && sb.size() != 0) begin
            check("issue_len", 32'(issue_len), 32'(sb[0].issue));
        end

        if (rq_ack != 3'b000 && prev_ack == 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(rq_ack), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("ack_onehot", 32'(rq_ack), 32'(cur.gnt));
                check("ack_grant", 32'(grant), 32'(cur.gnt));
                check("ack_rdata", rq_data_o, cur.rdata);
                check("ack_timeout", 32'(arb_timeout), 32'(cur.to));
                check("ack_state", 32'(arb_state), 32'(S_RELEASE));
            end
            ack_len = 1;
        end else if (rq_ack != 3'b000) begin
            ack_len++;
            check("timeout_pulse", 32'(arb_timeout), 32'd0);
            check("hold_grant", 32'(grant), 32'(cur.gnt));
        end else if (prev_ack != 3'b000) begin
            check("ack_len", 32'(ack_len), 32'(cur.dur));
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_state", 32'(arb_state), 32'(S_IDLE));
            fall_cyc = cyc;
        end

        for (int i = 0; i < 3; i++) begin
            if (rq_ack[i]) begin
                if (drop_cnt[i] >= req_hold) begin
                    rq_ren[i] = 1'b0;
                    rq_wen[i] = 1'b0;
                end else begin
                    drop_cnt[i]++;
                end
            end else begin
                drop_cnt[i] = 0;
            end
        end
        prev_mem = mem_act;
        prev_ack = rq_ack;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = (sb.size() == 0) && (rq_ren == 3'b000) && (rq_wen == 3'b000) &&
                   (rq_ack == 3'b000) && (arb_state == S_IDLE);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (!done) begin
            sb.delete();
            rq_ren = 3'b000;
            rq_wen = 3'b000;
        end
    endtask

    task automatic wait_issue(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = mem_ren | mem_wen;
        end
        check({tag, "_issue_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b0; rq_ren = 3'b000; rq_wen = 3'b000; rq_addr = 96'd0; rq_data_i = 96'd0;
        mem_ack = 1'b0; mem_data_o = IDLE_DATA;
        ack_delay = 3; ack_hold = 0; req_hold = 0; never_ack = 1'b0;
        for (int i = 0; i < 3; i++) drop_cnt[i] = 0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_state", 32'(arb_state), 32'(S_IDLE));
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(rq_ack), 32'd0);
        check("rst_rdata", rq_data_o, 32'd0);
        check("rst_mem", {30'd0, mem_ren, mem_wen}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_timeout", 32'(arb_timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("post_rst_state", 32'(arb_state), 32'(S_IDLE));

        // Single read from CPU data, ack after three issue cycles
        push(3'b010, 32'h8000_0010, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 1'b0, 3, 1, 1'b0);
        drive(1, 1'b1, 32'h8000_0010, 32'h1111_1111);
        wait_done("single_read", 30);

        // Single write from CPU fetch, immediate ack: write data returns 0
        ack_delay = 1;
        push(3'b100, 32'h0000_2000, 32'hCAFE_0002, 1'b0, 32'd0, 1'b0, 1, 1, 1'b0);
        drive(2, 1'b0, 32'h0000_2000, 32'hCAFE_0002);
        wait_done("single_write", 30);

        // All three at once, then requester 0 again
        ack_delay = 2;
        push(3'b001, 32'h0000_0100, 32'hA000_0000, 1'b1, rd_val(32'h0000_0100), 1'b0, 2, 1, 1'b0);
        push(3'b010, 32'h0000_0200, 32'hA000_0001, 1'b1, rd_val(32'h0000_0200), 1'b0, 2, 1, 1'b1);
        push(3'b100, 32'h0000_0300, 32'hA000_0002, 1'b1, rd_val(32'h0000_0300), 1'b0, 2, 1, 1'b1);
        drive(0, 1'b1, 32'h0000_0100, 32'hA000_0000);
        drive(1, 1'b1, 32'h0000_0200, 32'hA000_0001);
        drive(2, 1'b1, 32'h0000_0300, 32'hA000_0002);
        wait_done("simultaneous", 60);
        push(3'b001, 32'h0000_0104, 32'hA000_0003, 1'b1, rd_val(32'h0000_0104), 1'b0, 2, 1, 1'b0);
        drive(0, 1'b1, 32'h0000_0104, 32'hA000_0003);
        wait_done("rerequest0", 30);

        // Requester 0 arrives while 1 is in ISSUE with 2 pending: policy decides who is next
`ifdef MEM_ARB_RR_EN
        push(3'b010, 32'h0000_0400, 32'hB000_0001, 1'b1, rd_val(32'h0000_0400), 1'b0, 2, 1, 1'b0);
        push(3'b100, 32'h0000_0500, 32'hB000_0002, 1'b0, 32'd0, 1'b0, 2, 1, 1'b1);
        push(3'b001, 32'h0000_0600, 32'hB000_0000, 1'b1, rd_val(32'h0000_0600), 1'b0, 2, 1, 1'b1);
`else
        push(3'b010, 32'h0000_0400, 32'hB000_0001, 1'b1, rd_val(32'h0000_0400), 1'b0, 2, 1, 1'b0);
        push(3'b001, 32'h0000_0600, 32'hB000_0000, 1'b1, rd_val(32'h0000_0600), 1'b0, 2, 1, 1'b1);
        push(3'b100, 32'h0000_0500, 32'hB000_0002, 1'b0, 32'd0, 1'b0, 2, 1, 1'b1);
`endif
        drive(1, 1'b1, 32'h0000_0400, 32'hB000_0001);
        drive(2, 1'b0, 32'h0000_0500, 32'hB000_0002);
        wait_issue("priority");
        drive(0, 1'b1, 32'h0000_0600, 32'hB000_0000);
        wait_done("priority", 60);

        // Timeout: write with no memory acknowledge
        never_ack = 1'b1;
        push(3'b001, 32'h0000_0700, 32'hC000_0000, 1'b0, 32'd0, 1'b1, 200, 1, 1'b0);
        drive(0, 1'b0, 32'h0000_0700, 32'hC000_0000);
        wait_done("timeout", 400);
        never_ack = 1'b0;

        // Late release: ack held 5 cycles after the strobe falls, a new request waits
        ack_hold = 5;
        push(3'b100, 32'h0000_0800, 32'hD000_0002, 1'b1, rd_val(32'h0000_0800), 1'b0, 2, 6, 1'b0);
        push(3'b001, 32'h0000_0900, 32'hD000_0000, 1'b0, 32'd0, 1'b0, 2, 6, 1'b1);
        drive(2, 1'b1, 32'h0000_0800, 32'hD000_0002);
        wait_issue("late_ack");
        drive(0, 1'b0, 32'h0000_0900, 32'hD000_0000);
        wait_done("late_ack", 60);

        // Late release from the requester side: request held 3 cycles after ack
        ack_hold = 0;
        req_hold = 3;
        push(3'b010, 32'h0000_0A00, 32'hD000_0001, 1'b1, rd_val(32'h0000_0A00), 1'b0, 2, 4, 1'b0);
        drive(1, 1'b1, 32'h0000_0A00, 32'hD000_0001);
        wait_done("late_req", 30);
        req_hold = 0;

        // Reset in the middle of a write
        never_ack = 1'b1;
        push(3'b001, 32'h0000_0B00, 32'hE000_0000, 1'b0, 32'd0, 1'b0, 1, 1, 1'b0);
        drive(0, 1'b0, 32'h0000_0B00, 32'hE000_0000);
        wait_issue("mid_rst");
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wen", 32'(mem_wen), 32'd0);
        check("mid_rst_ren", 32'(mem_ren), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_ack", 32'(rq_ack), 32'd0);
        check("mid_rst_state", 32'(arb_state), 32'(S_IDLE));
        check("mid_rst_rdata", rq_data_o, 32'd0);
        sb.delete();
        rq_ren = 3'b000; rq_wen = 3'b000;
        never_ack = 1'b0; mem_ack = 1'b0; mem_data_o = IDLE_DATA;
        req_cycles = 0; hold_cnt = 0; prev_mem = 1'b0; prev_ack = 3'b000;
        @(posedge clk);
        #1 rst = 1'b0;

        // After reset requester 0 leads again
        push(3'b001, 32'h0000_0C00, 32'hF000_0000, 1'b1, rd_val(32'h0000_0C00), 1'b0, 2, 1, 1'b0);
        push(3'b010, 32'h0000_0D00, 32'hF000_0001, 1'b1, rd_val(32'h0000_0D00), 1'b0, 2, 1, 1'b1);
        drive(0, 1'b1, 32'h0000_0C00, 32'hF000_0000);
        drive(1, 1'b1, 32'h0000_0D00, 32'hF000_0001);
        wait_done("post_rst", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
